// File: rtl/truth_table_sweeper.sv
// Self-test sequencer for a 3-input, 1-output logic block. It steps the inputs
// through all 8 rows, samples the block output and compares the 8-bit table.
module truth_table_sweeper #(
  parameter int unsigned SETTLE   = 4,
  parameter logic [7:0]  EXPECTED = 8'h9A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       table_valid,
  output logic [7:0] tt,
  output logic       match,
  output logic [7:0] mismatch
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] APPLY  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tt_q, tt_d;
  logic [7:0] mm_q, mm_d;
  logic       tv_q, tv_d;
  logic       match_q, match_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    mm_d    = mm_q;
    tv_d    = tv_q;
    match_d = match_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          row_d   = 3'd0;
          cnt_d   = 8'd0;
          tt_d    = 8'h00;
          mm_d    = 8'h00;
          tv_d    = 1'b0;
          match_d = 1'b0;
        end
      end
      APPLY: begin
        if (abort) begin
          state_d = IDLE;
          row_d   = 3'd0;
          cnt_d   = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
          row_d   = 3'd0;
          cnt_d   = 8'd0;
        end else begin
          // Row 000 lands in the MSB (Cello hex ordering).
          tt_d[3'd7 - row_q] = dut_out;
          cnt_d = 8'd0;
          if (row_q == 3'd7) begin
            state_d = DONE;
            row_d   = 3'd0;
            tv_d    = 1'b1;
            match_d = (tt_d == EXPECTED);
            mm_d    = tt_d ^ EXPECTED;
          end else begin
            state_d = APPLY;
            row_d   = row_q + 3'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= 3'd0;
      cnt_q   <= 8'd0;
      tt_q    <= 8'h00;
      mm_q    <= 8'h00;
      tv_q    <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      mm_q    <= mm_d;
      tv_q    <= tv_d;
      match_q <= match_d;
    end
  end

  // Row register is the DUT drive; it is parked at 000 outside a sweep.
  assign {in1, in2, in3} = row_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign table_valid = tv_q;
  assign tt          = tt_q;
  assign match       = match_q;
  assign mismatch    = mm_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: two sweeper instances (SETTLE=2 and SETTLE=1) each driving
// a selectable 0x9A logic model (combinational, faulty, or 2-stage registered).
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n, st, abort;
  logic sel;       // 0: SETTLE=2 instance, 1: SETTLE=1 instance
  int   mode;      // 0: comb 0x9A, 1: row 011 stuck 0, 2: 2-stage registered 0x9A
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic       a_in1, a_in2, a_in3, a_out, a_busy, a_done, a_tv, a_match;
  logic [7:0] a_tt, a_mm;
  logic       b_in1, b_in2, b_in3, b_out, b_busy, b_done, b_tv, b_match;
  logic [7:0] b_tt, b_mm;
  logic       start_a, start_b;

  assign start_a = st & ~sel;
  assign start_b = st & sel;

  truth_table_sweeper #(.SETTLE(2), .EXPECTED(8'h9A)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
    .in1(a_in1), .in2(a_in2), .in3(a_in3), .dut_out(a_out),
    .busy(a_busy), .done(a_done), .table_valid(a_tv), .tt(a_tt),
    .match(a_match), .mismatch(a_mm));

  truth_table_sweeper #(.SETTLE(1), .EXPECTED(8'h9A)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
    .in1(b_in1), .in2(b_in2), .in3(b_in3), .dut_out(b_out),
    .busy(b_busy), .done(b_done), .table_valid(b_tv), .tt(b_tt),
    .match(b_match), .mismatch(b_mm));

  function automatic logic fmodel(input int m, input logic [2:0] r);
    logic [7:0] t;
    logic v;
    t = 8'h9A;
    v = t[3'd7 - r];
    if (m == 1 && r == 3'd3) v = 1'b0;
    return v;
  endfunction

  wire [2:0] row_a = {a_in1, a_in2, a_in3};
  wire [2:0] row_b = {b_in1, b_in2, b_in3};
  logic pa1, pa2, pb1, pb2;
  always @(posedge clk) begin
    pa1 <= fmodel(0, row_a); pa2 <= pa1;
    pb1 <= fmodel(0, row_b); pb2 <= pb1;
  end
  assign a_out = (mode == 2) ? pa2 : fmodel(mode, row_a);
  assign b_out = (mode == 2) ? pb2 : fmodel(mode, row_b);

  wire [2:0] o_row   = sel ? row_b   : row_a;
  wire       o_busy  = sel ? b_busy  : a_busy;
  wire       o_done  = sel ? b_done  : a_done;
  wire       o_tv    = sel ? b_tv    : a_tv;
  wire       o_match = sel ? b_match : a_match;
  wire [7:0] o_tt    = sel ? b_tt    : a_tt;
  wire [7:0] o_mm    = sel ? b_mm    : a_mm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulses start, then tracks the row sequence until done; returns latency
  // (start edge to done cycle) or -1 if done never arrives.
  task automatic sweep(input int s, input bit spam, output int lat, output bit row_ok);
    int c;
    row_ok = 1'b1;
    lat = -1;
    @(negedge clk); st = 1'b1;
    @(negedge clk); st = 1'b0;
    for (c = 0; c < 400; c++) begin
      if (o_done) begin
        lat = c + 1;
        break;
      end
      if (o_row !== 3'(c / (s + 1)) || o_busy !== 1'b1) row_ok = 1'b0;
      st = spam && (c % 4 == 1);
      @(negedge clk);
    end
    st = 1'b0;
  endtask

  task automatic wait_row(input logic [2:0] r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (o_row == r) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    int         mode;
    logic       sel;
    int         settle;
    bit         spam;
    logic [7:0] tt;
    logic       match;
    logic [7:0] mm;
    int         lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int  lat;
    bit  ok;
    int  ndone;

    vecs[0] = '{0, 1'b0, 2, 1'b0, 8'h9A, 1'b1, 8'h00, 25};
    vecs[1] = '{1, 1'b0, 2, 1'b0, 8'h8A, 1'b0, 8'h10, 25};
    vecs[2] = '{2, 1'b0, 2, 1'b0, 8'h9A, 1'b1, 8'h00, 25};
    vecs[3] = '{2, 1'b1, 1, 1'b0, 8'hCD, 1'b0, 8'h57, 17};
    vecs[4] = '{0, 1'b0, 2, 1'b1, 8'h9A, 1'b1, 8'h00, 25};

    rst_n = 1'b0; st = 1'b0; abort = 1'b0; mode = 0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_a", {a_in1, a_in2, a_in3, a_busy, a_done, a_tv, a_match, a_tt, a_mm}, 0);
    chk("reset_b", {b_in1, b_in2, b_in3, b_busy, b_done, b_tv, b_match, b_tt, b_mm}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      sel  = vecs[i].sel;
      repeat (4) @(negedge clk);
      sweep(vecs[i].settle, vecs[i].spam, lat, ok);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_rows", i), ok, 1);
      chk($sformatf("v%0d_tt", i), o_tt, vecs[i].tt);
      chk($sformatf("v%0d_match", i), o_match, vecs[i].match);
      chk($sformatf("v%0d_mismatch", i), o_mm, vecs[i].mm);
      chk($sformatf("v%0d_valid", i), o_tv, 1);
      @(negedge clk);
      chk($sformatf("v%0d_done_once", i), {o_done, o_busy, o_row}, 0);
      chk($sformatf("v%0d_hold", i), {o_tv, o_tt}, {1'b1, vecs[i].tt});
    end

    // Earliest restart: start in the cycle right after done.
    mode = 0; sel = 1'b0;
    sweep(2, 1'b0, lat, ok);
    @(negedge clk); st = 1'b1;
    @(negedge clk); st = 1'b0;
    chk("restart_busy", {a_busy, a_tv, a_tt}, {1'b1, 1'b0, 8'h00});
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (a_done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("restart_done", {ok, a_tt, a_match}, {1'b1, 8'h9A, 1'b1});
    repeat (3) @(negedge clk);

    // Abort during row 4.
    @(negedge clk); st = 1'b1;
    @(negedge clk); st = 1'b0;
    wait_row(3'd4, ok);
    chk("abort_reach_row4", ok, 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_idle", {a_busy, a_done, a_tv, row_a}, 0);
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (a_done || a_busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    sweep(2, 1'b0, lat, ok);
    chk("abort_resweep", {lat, a_tt, a_match, a_tv}, {32'd25, 8'h9A, 1'b1, 1'b1});
    repeat (3) @(negedge clk);

    // Reset pulse during row 6.
    @(negedge clk); st = 1'b1;
    @(negedge clk); st = 1'b0;
    wait_row(3'd6, ok);
    chk("rst_reach_row6", ok, 1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("rst_mid_outputs", {a_in1, a_in2, a_in3, a_busy, a_done, a_tv, a_match, a_tt, a_mm}, 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_idle", a_busy, 0);
    sweep(2, 1'b0, lat, ok);
    chk("rst_resweep", {lat, ok, a_tt, a_match, a_mm}, {32'd25, 1'b1, 8'h9A, 1'b1, 8'h00});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
